// File: rtl/rv32i_control_pkg.sv
// Shared control types for the RV32I pipeline sequencer: hazard FSM states,
// the bundle of stage-register stall/flush enables, and register-file width.
package rv32i_control_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN         = 2'd0,
        HZ_WAIT_GNT    = 2'd1,
        HZ_WAIT_RVALID = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_IDLE = '0;

endpackage

// File: rtl/rv32i_load_use_detector.sv
// Combinational load-use hazard compare: the ID instruction reads a register
// that the load currently in EX has not produced yet. x0 never hazards.
module rv32i_load_use_detector
    import rv32i_control_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_memread_i,
    output logic                  hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Match each used ID source against the EX load destination.
    always_comb begin
        rs1_hit  = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit  = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
        hazard_o = ex_memread_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/rv32i_hazard_controller.sv
// Central pipeline sequencer: load-use bubbles, data-memory wait freeze,
// wrong-path squash on EX redirects, a memory watchdog and a saturating
// count of cycles in which the PC was held.
//
// Data-memory handshake: dmem_req_i is held by the MEM stage until the access
// completes; a request is accepted in the cycle dmem_gnt_i is high; a store
// completes on acceptance, a load completes in the first cycle after
// acceptance in which dmem_rvalid_i is high (rvalid in the grant cycle itself
// does not count). The pipeline is frozen in every cycle the access has not
// completed, and released in the completing cycle.
module rv32i_hazard_controller
    import rv32i_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [4:0]             id_rs1_addr_i,
    input  logic [4:0]             id_rs2_addr_i,
    input  logic                   id_uses_rs1_i,
    input  logic                   id_uses_rs2_i,
    input  logic [4:0]             ex_rd_addr_i,
    input  logic                   ex_memread_i,
    input  logic                   branch_taken_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_we_i,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    output logic                   pc_stall_o,
    output logic                   if_id_stall_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_stall_o,
    output logic                   id_ex_flush_o,
    output logic                   ex_mem_stall_o,
    output logic                   mem_wb_flush_o,
    output logic                   mem_err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output hazard_state_e          dbg_state_o
);

    // The wait counter only has to reach MEM_TIMEOUT-1 before the abort.
    localparam int unsigned WAIT_CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);
    localparam bit WDOG_EN = (MEM_TIMEOUT != 0);

    hazard_state_e          state_q;
    hazard_state_e          state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q;
    logic [WAIT_CNT_W-1:0]  wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;
    logic                   waiting;
    logic                   abort;
    logic                   mem_wait;
    logic                   load_use;
    pipe_ctrl_t             ctrl;

    rv32i_load_use_detector u_load_use (
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_memread_i  (ex_memread_i),
        .hazard_o      (load_use)
    );

    // State register plus watchdog and stall-cycle counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Decide whether the current memory access is still outstanding this
    // cycle, and whether the watchdog gives up on it instead.
    always_comb begin
        case (state_q)
            HZ_RUN:         waiting = dmem_req_i && (!dmem_gnt_i || !dmem_we_i);
            HZ_WAIT_GNT:    waiting = !(dmem_gnt_i && dmem_we_i);
            HZ_WAIT_RVALID: waiting = !dmem_rvalid_i;
            default:        waiting = 1'b0;
        endcase
        abort    = WDOG_EN && waiting && (wait_cnt_q == WAIT_LAST);
        mem_wait = waiting && !abort;
    end

    // Next-state logic; the watchdog counter spans the whole access, from
    // the request cycle in RUN until release or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN: begin
                if (dmem_req_i) begin
                    if (!dmem_gnt_i) begin
                        state_d = HZ_WAIT_GNT;
                    end else if (!dmem_we_i) begin
                        state_d = HZ_WAIT_RVALID;
                    end
                end
            end
            HZ_WAIT_GNT: begin
                if (dmem_gnt_i) begin
                    state_d = dmem_we_i ? HZ_RUN : HZ_WAIT_RVALID;
                end
            end
            HZ_WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
        if (abort) begin
            state_d = HZ_RUN;
        end

        if (!waiting || abort) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Stage enables: a memory freeze dominates; otherwise a redirect squashes
    // IF/ID and ID/EX and lets the PC move; otherwise a load-use inserts one bubble.
    always_comb begin
        ctrl = PIPE_CTRL_IDLE;
        if (mem_wait) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (branch_taken_i) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end
    end

    // Count PC-hold cycles, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign pc_stall_o     = ctrl.pc_stall;
    assign if_id_stall_o  = ctrl.if_id_stall;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_stall_o  = ctrl.id_ex_stall;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_stall_o = ctrl.ex_mem_stall;
    assign mem_wb_flush_o = ctrl.mem_wb_flush;
    assign mem_err_o      = abort;
    assign stall_cnt_o    = stall_cnt_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rv32i_hazard_controller.sv
// Bench for rv32i_hazard_controller: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_rv32i_hazard_controller;
    import rv32i_control_pkg::*;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned STALL_CNT_W = 4;
    localparam int VEC_W = 2 + 1 + 7 + STALL_CNT_W;
    localparam int CNT_MAX = (1 << STALL_CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                   clk_i;
    logic                   rst_ni;
    logic [4:0]             id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic                   id_uses_rs1_i, id_uses_rs2_i, ex_memread_i, branch_taken_i;
    logic                   dmem_req_i, dmem_we_i, dmem_gnt_i, dmem_rvalid_i;
    logic                   pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic                   id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_err_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    hazard_state_e          dbg_state_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    rv32i_hazard_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_uses_rs1_i  (id_uses_rs1_i),
        .id_uses_rs2_i  (id_uses_rs2_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_memread_i   (ex_memread_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_we_i      (dmem_we_i),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .pc_stall_o     (pc_stall_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_stall_o  (id_ex_stall_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .ex_mem_stall_o (ex_mem_stall_o),
        .mem_wb_flush_o (mem_wb_flush_o),
        .mem_err_o      (mem_err_o),
        .stall_cnt_o    (stall_cnt_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    logic [VEC_W-1:0] exp_q[$];
    int               tag_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               step_no  = 0;

    // Reference model: one memory access seen as a transaction with an age.
    bit m_open;
    bit m_granted;
    int m_age;
    int m_stall_cnt;

    function automatic logic [VEC_W-1:0] dut_vec();
        return {dbg_state_o, mem_err_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
                id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, stall_cnt_o};
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_open      = 1'b0;
        m_granted   = 1'b0;
        m_age       = 0;
        m_stall_cnt = 0;
    endtask

    // Expected outputs for the inputs currently applied; then advance a cycle.
    task automatic model_step(output logic [VEC_W-1:0] exp_v);
        hazard_state_e st;
        bit done, waiting, abort, freeze, hazard, redirect, bubble, pc_s;
        if (!m_open)         st = HZ_RUN;
        else if (!m_granted) st = HZ_WAIT_GNT;
        else                 st = HZ_WAIT_RVALID;

        if (!m_open && dmem_req_i) begin
            m_open    = 1'b1;
            m_granted = 1'b0;
            m_age     = 0;
        end
        done = 1'b0;
        if (m_open) begin
            if (!m_granted) begin
                if (dmem_gnt_i) begin
                    m_granted = 1'b1;
                    done      = dmem_we_i;
                end
            end else begin
                done = dmem_rvalid_i;
            end
        end
        waiting  = m_open && !done;
        abort    = waiting && (MEM_TIMEOUT != 0) && (m_age == int'(MEM_TIMEOUT) - 1);
        freeze   = waiting && !abort;
        hazard   = ex_memread_i && (ex_rd_addr_i != 0) &&
                   ((id_uses_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
                    (id_uses_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
        redirect = branch_taken_i && !freeze;
        bubble   = hazard && !freeze;
        pc_s     = freeze || (bubble && !redirect);
        exp_v = {st, abort, pc_s, pc_s, redirect, freeze, redirect || bubble,
                 freeze, freeze, STALL_CNT_W'(m_stall_cnt)};
        if (pc_s && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (done || abort) m_open = 1'b0;
        else if (m_open)   m_age++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] exrd,
                        input logic mr, input logic br, input logic req,
                        input logic we, input logic gnt, input logic rv);
        logic [VEC_W-1:0] e;
        @(posedge clk_i);
        #1;
        id_rs1_addr_i  = rs1;
        id_rs2_addr_i  = rs2;
        id_uses_rs1_i  = u1;
        id_uses_rs2_i  = u2;
        ex_rd_addr_i   = exrd;
        ex_memread_i   = mr;
        branch_taken_i = br;
        dmem_req_i     = req;
        dmem_we_i      = we;
        dmem_gnt_i     = gnt;
        dmem_rvalid_i  = rv;
        model_step(e);
        exp_q.push_back(e);
        tag_q.push_back(step_no);
        step_no++;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_zero();
        id_rs1_addr_i  = '0;
        id_rs2_addr_i  = '0;
        id_uses_rs1_i  = 1'b0;
        id_uses_rs2_i  = 1'b0;
        ex_rd_addr_i   = '0;
        ex_memread_i   = 1'b0;
        branch_taken_i = 1'b0;
        dmem_req_i     = 1'b0;
        dmem_we_i      = 1'b0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic pulse_reset();
        @(negedge clk_i);
        #1;
        drive_zero();
        rst_ni = 1'b0;
        #1;
        check_val("reset_ctrl_outputs",
                  {24'd0, mem_err_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
                   id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o}, 32'd0);
        check_val("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check_val("reset_state", 32'(dbg_state_o), 32'(HZ_RUN));
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [VEC_W-1:0] exp_v;
        logic [VEC_W-1:0] got_v;
        int               tag;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                got_v = dut_vec();
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle_outputs step %0d: got %h expected %h (state,err,pc_s,ifid_s,ifid_f,idex_s,idex_f,exmem_s,memwb_f,cnt)",
                             tag, got_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        drive_zero();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        check_val("por_pc_stall", 32'(pc_stall_o), 32'd0);
        check_val("por_mem_err", 32'(mem_err_o), 32'd0);
        check_val("por_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check_val("por_state", 32'(dbg_state_o), 32'(HZ_RUN));
        #9 rst_ni = 1'b1;

        // Load x5 in EX, ID reads x5 via rs1: one bubble.
        step(5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_val("load_use_pc_stall", 32'(pc_stall_o), 32'd1);
        idle();
        // Load to x0 never hazards.
        step(5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_val("load_x0_pc_stall", 32'(pc_stall_o), 32'd0);
        idle();
        // Store granted in the request cycle: no stall.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();

        // Store granted after 3 cycles: 3 stall cycles, counter reads 3.
        pulse_reset();
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        #1 check_val("store_wait_stall_cnt", 32'(stall_cnt_o), 32'd3);

        // Load granted at once, data two cycles later.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Redirect with a load-use hazard: squash, PC not held.
        step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_val("branch_over_load_use_pc_stall", 32'(pc_stall_o), 32'd0);
        check_val("branch_over_load_use_if_id_flush", 32'(if_id_flush_o), 32'd1);
        idle();
        // Same during a memory wait: only the freeze, flushes in the release cycle.
        repeat (2) step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();

        // Grant never comes: 3 stall cycles then the watchdog abort.
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check_val("watchdog_mem_err", 32'(mem_err_o), 32'd1);
        check_val("watchdog_pc_stall", 32'(pc_stall_o), 32'd0);
        idle();

        // Reset during WAIT_RVALID; a late rvalid is ignored.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 check_val("late_rvalid_state", 32'(dbg_state_o), 32'(HZ_RUN));
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        idle();

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
